// File: rtl/gshare_bpu_pkg.sv
// Shared definitions for the gshare branch prediction unit: 2-bit counter
// encodings, saturating counter update and the init/run state type.
package bpu_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpu_state_e;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_bpu_if.sv
// Decode-lookup and execute-update bundle between the core pipeline and the BPU.
// Lookup outputs are combinational; no backpressure, every update is accepted.
interface gshare_bpu_if #(
  parameter int HIST_BITS     = 14,
  parameter int BHT_ADDR_BITS = 10,
  parameter int RAS_PTR_BITS  = 2
);

  logic                     pred_valid;
  logic [31:0]              pred_pc;
  logic                     pred_is_branch;
  logic                     pred_is_call;
  logic                     pred_is_ret;
  logic                     pred_taken;
  logic [BHT_ADDR_BITS-1:0] pred_index;
  logic [HIST_BITS-1:0]     pred_ghr;
  logic [RAS_PTR_BITS-1:0]  pred_ras_ptr;
  logic [RAS_PTR_BITS:0]    pred_ras_cnt;
  logic [31:0]              ras_target;
  logic                     ras_target_valid;

  logic                     upd_valid;
  logic                     upd_is_branch;
  logic                     upd_taken;
  logic [BHT_ADDR_BITS-1:0] upd_index;
  logic                     upd_mispredict;
  logic [HIST_BITS-1:0]     upd_ghr;
  logic [RAS_PTR_BITS-1:0]  upd_ras_ptr;
  logic [RAS_PTR_BITS:0]    upd_ras_cnt;
  logic [31:0]              ret_addr;

  modport master (
    output pred_valid, pred_pc, pred_is_branch, pred_is_call, pred_is_ret,
    output upd_valid, upd_is_branch, upd_taken, upd_index, upd_mispredict,
    output upd_ghr, upd_ras_ptr, upd_ras_cnt, ret_addr,
    input  pred_taken, pred_index, pred_ghr, pred_ras_ptr, pred_ras_cnt,
    input  ras_target, ras_target_valid
  );

  modport slave (
    input  pred_valid, pred_pc, pred_is_branch, pred_is_call, pred_is_ret,
    input  upd_valid, upd_is_branch, upd_taken, upd_index, upd_mispredict,
    input  upd_ghr, upd_ras_ptr, upd_ras_cnt, ret_addr,
    output pred_taken, pred_index, pred_ghr, pred_ras_ptr, pred_ras_cnt,
    output ras_target, ras_target_valid
  );

endinterface

// File: rtl/gshare_bpu_ras.sv
// Circular return-address stack with pointer/occupancy checkpoint restore.
// Top-of-stack read is combinational; push/pop commit next edge, no backpressure.
module bpu_ras
  import bpu_pkg::*;
#(
  parameter int RAS_DEPTH    = 4,
  parameter int RAS_PTR_BITS = $clog2(RAS_DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic                    push,
  input  logic                    pop,
  input  logic [31:0]             push_addr,
  input  logic                    restore,
  input  logic [RAS_PTR_BITS-1:0] restore_ptr,
  input  logic [RAS_PTR_BITS:0]   restore_cnt,
  output logic [RAS_PTR_BITS-1:0] ptr,
  output logic [RAS_PTR_BITS:0]   cnt,
  output logic [31:0]             top,
  output logic                    top_valid
);

  localparam logic [RAS_PTR_BITS-1:0] PTR_ONE   = RAS_PTR_BITS'(1);
  localparam logic [RAS_PTR_BITS:0]   CNT_ONE   = (RAS_PTR_BITS+1)'(1);
  localparam logic [RAS_PTR_BITS:0]   CNT_FULL  = (RAS_PTR_BITS+1)'(RAS_DEPTH);

  logic [31:0]             stack [RAS_DEPTH];
  logic [RAS_PTR_BITS-1:0] top_idx, wr_idx;
  logic                    pop_ok, wr_en;

  assign top_idx   = ptr - PTR_ONE;
  assign top       = stack[top_idx];
  assign top_valid = (cnt != '0);
  assign pop_ok    = pop & top_valid;
  assign wr_en     = en & ~restore & push;
  // call+ret on a non-empty stack replaces the top entry in place
  assign wr_idx    = pop_ok ? top_idx : ptr;

  always_ff @(posedge clk) begin
    if (wr_en) stack[wr_idx] <= push_addr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
      cnt <= '0;
    end else if (en) begin
      if (restore) begin
        ptr <= restore_ptr;
        cnt <= restore_cnt;
      end else if (push && !pop_ok) begin
        ptr <= ptr + PTR_ONE;
        if (cnt != CNT_FULL) cnt <= cnt + CNT_ONE;
      end else if (pop_ok && !push) begin
        ptr <= top_idx;
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/gshare_bpu.sv
// Gshare direction predictor with speculative GHR, checkpoint repair and a RAS.
// Lookup is zero-latency combinational; updates commit next edge, no backpressure.
module gshare_bpu
  import bpu_pkg::*;
#(
  parameter int HIST_BITS     = 14,
  parameter int BHT_ADDR_BITS = 10,
  parameter int RAS_DEPTH     = 4,
  parameter int RAS_PTR_BITS  = $clog2(RAS_DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        init_done,
  gshare_bpu_if.slave bus
);

  localparam int BHT_ENTRIES = 1 << BHT_ADDR_BITS;
  localparam int FOLD_BITS   = (HIST_BITS >= BHT_ADDR_BITS) ? BHT_ADDR_BITS : HIST_BITS;

  bpu_state_e               state;
  logic [BHT_ADDR_BITS-1:0] sweep_cnt, pidx, ghr_fold;
  logic [HIST_BITS-1:0]     ghr;
  logic [1:0]               bht [BHT_ENTRIES];
  logic                     run, train, repair, spec_shift, ras_top_valid, unused_pc;

  assign run        = (state == RUN);
  assign ghr_fold   = BHT_ADDR_BITS'(ghr[FOLD_BITS-1:0]);
  assign pidx       = bus.pred_pc[BHT_ADDR_BITS+1:2] ^ ghr_fold;
  assign unused_pc  = ^{bus.pred_pc[31:BHT_ADDR_BITS+2], bus.pred_pc[1:0]};

  assign bus.pred_index       = pidx;
  assign bus.pred_taken       = run & bht[pidx][1] & bus.pred_is_branch;
  assign bus.pred_ghr         = ghr;
  assign bus.ras_target_valid = run & bus.pred_is_ret & ras_top_valid;

  assign train      = run & bus.upd_valid & bus.upd_is_branch;
  assign repair     = run & bus.upd_valid & bus.upd_mispredict;
  assign spec_shift = run & bus.pred_valid & bus.pred_is_branch & ~bus.upd_mispredict;

  // Single write port: the init sweep owns it until RUN, then training does
  always_ff @(posedge clk) begin
    if (!run) bht[sweep_cnt] <= WNT;
    else if (train) bht[bus.upd_index] <= sat_update(bht[bus.upd_index], bus.upd_taken);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= run;
      if (!run) begin
        sweep_cnt <= sweep_cnt + BHT_ADDR_BITS'(1);
        if (&sweep_cnt) state <= RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr <= '0;
    end else if (repair) begin
      ghr <= bus.upd_is_branch ? {bus.upd_ghr[HIST_BITS-2:0], bus.upd_taken} : bus.upd_ghr;
    end else if (spec_shift) begin
      ghr <= {ghr[HIST_BITS-2:0], bus.pred_taken};
    end
  end

  bpu_ras #(
    .RAS_DEPTH    (RAS_DEPTH),
    .RAS_PTR_BITS (RAS_PTR_BITS)
  ) u_ras (
    .clk         (clk),
    .resetn      (resetn),
    .en          (run),
    .push        (bus.pred_valid & bus.pred_is_call),
    .pop         (bus.pred_valid & bus.pred_is_ret),
    .push_addr   (bus.ret_addr),
    .restore     (repair),
    .restore_ptr (bus.upd_ras_ptr),
    .restore_cnt (bus.upd_ras_cnt),
    .ptr         (bus.pred_ras_ptr),
    .cnt         (bus.pred_ras_cnt),
    .top         (bus.ras_target),
    .top_valid   (ras_top_valid)
  );

endmodule
